// File: rtl/fsk_mod.sv
// Continuous-phase binary FSK modulator: each accepted bit becomes SAMPLES_PER_BIT
// sine samples whose phase step depends on the bit value; back-to-back bits keep phase.
module fsk_mod #(
  parameter int         SAMPLES_PER_BIT = 64,
  parameter logic [7:0] F0_STEP         = 8'd4,
  parameter logic [7:0] F1_STEP         = 8'd8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic       bit_ready,
  output logic [7:0] data_out,
  output logic       data_valid
);

  localparam int            CW   = $clog2(SAMPLES_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(SAMPLES_PER_BIT - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t        state;
  logic [7:0]    phase;
  logic [CW-1:0] count;
  logic          cur_bit;

  logic          accept;
  logic          next_bit;
  logic [7:0]    step;

  // Quarter-wave table (0..16) mirrored into a full 64-entry 128 +/- 127*sin period.
  function automatic logic [7:0] sine_lut(input logic [5:0] idx);
    logic [4:0] pos;
    logic [4:0] qi;
    logic [6:0] amp;
    pos = idx[4:0];
    qi  = (pos > 5'd16) ? (5'd0 - pos) : pos;
    case (qi)
      5'd0:    amp = 7'd0;
      5'd1:    amp = 7'd12;
      5'd2:    amp = 7'd25;
      5'd3:    amp = 7'd37;
      5'd4:    amp = 7'd49;
      5'd5:    amp = 7'd60;
      5'd6:    amp = 7'd71;
      5'd7:    amp = 7'd81;
      5'd8:    amp = 7'd90;
      5'd9:    amp = 7'd98;
      5'd10:   amp = 7'd106;
      5'd11:   amp = 7'd112;
      5'd12:   amp = 7'd117;
      5'd13:   amp = 7'd122;
      5'd14:   amp = 7'd125;
      5'd15:   amp = 7'd126;
      default: amp = 7'd127;
    endcase
    return idx[5] ? (8'd128 - {1'b0, amp}) : (8'd128 + {1'b0, amp});
  endfunction

  // A newly accepted bit takes effect on the very sample it starts, so it picks the step.
  assign accept   = bit_valid & bit_ready;
  assign next_bit = accept ? bit_in : cur_bit;
  assign step     = next_bit ? F1_STEP : F0_STEP;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      phase      <= 8'd0;
      count      <= '0;
      cur_bit    <= 1'b0;
      data_out   <= 8'd128;
      data_valid <= 1'b0;
      bit_ready  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= SEND;
            cur_bit    <= bit_in;
            data_out   <= sine_lut(phase[7:2]);
            phase      <= phase + step;
            count      <= '0;
            data_valid <= 1'b1;
            bit_ready  <= 1'b0;
          end else begin
            data_out   <= 8'd128;
            data_valid <= 1'b0;
            phase      <= 8'd0;
            count      <= '0;
            bit_ready  <= 1'b1;
          end
        end
        SEND: begin
          if (accept || count != LAST) begin
            // Either mid-symbol or a gapless hand-over to the next bit; phase runs on.
            cur_bit    <= next_bit;
            data_out   <= sine_lut(phase[7:2]);
            phase      <= phase + step;
            data_valid <= 1'b1;
            count      <= accept ? '0 : count + 1'b1;
            bit_ready  <= !accept && (count + 1'b1 == LAST);
          end else begin
            state      <= IDLE;
            data_out   <= 8'd128;
            data_valid <= 1'b0;
            phase      <= 8'd0;
            count      <= '0;
            bit_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fsk_mod.sv
// Bench for fsk_mod: directed and random bit bursts compared sample-by-sample
// against a phase-accumulation model using a floating-point sine table.
module tb_fsk_mod;

  localparam int SPB_A = 64;
  localparam int SPB_B = 2;
  localparam int STEP0 = 4;
  localparam int STEP1 = 8;

  logic       clk;
  logic       rst_n;
  logic       bit_in_a, bit_valid_a, bit_ready_a, data_valid_a;
  logic [7:0] data_out_a;
  logic       bit_in_b, bit_valid_b, bit_ready_b, data_valid_b;
  logic [7:0] data_out_b;

  int errors = 0;
  int checks = 0;
  int lut_ref [64];

  fsk_mod #(.SAMPLES_PER_BIT(SPB_A)) u_dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_in     (bit_in_a),
    .bit_valid  (bit_valid_a),
    .bit_ready  (bit_ready_a),
    .data_out   (data_out_a),
    .data_valid (data_valid_a)
  );

  fsk_mod #(.SAMPLES_PER_BIT(SPB_B)) u_dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_in     (bit_in_b),
    .bit_valid  (bit_valid_b),
    .bit_ready  (bit_ready_b),
    .data_out   (data_out_b),
    .data_valid (data_valid_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input int inst, input logic b, input logic v);
    if (inst == 0) begin
      bit_in_a = b;
      bit_valid_a = v;
    end else begin
      bit_in_b = b;
      bit_valid_b = v;
    end
  endtask

  task automatic get_out(input int inst, output int d, output int v, output int r);
    if (inst == 0) begin
      d = int'(data_out_a);
      v = int'(data_valid_a);
      r = int'(bit_ready_a);
    end else begin
      d = int'(data_out_b);
      v = int'(data_valid_b);
      r = int'(bit_ready_b);
    end
  endtask

  // Send bits[0..nbits-1] as one burst with bit_valid held until the last hand-over.
  // Mid-symbol inputs are random noise that must be ignored. abort_at >= 0 returns
  // after that sample of the first bit, leaving the DUT mid-symbol.
  task automatic run_burst(input int inst, input int spb, input int nbits,
                           input logic [15:0] bits, input int abort_at);
    int phase;
    int d, v, r;
    phase = 0;
    @(negedge clk);
    get_out(inst, d, v, r);
    check_output("idle_data", d, 128);
    check_output("idle_valid", v, 0);
    check_output("idle_ready", r, 1);
    apply_stimulus(inst, bits[0], 1'b1);
    for (int i = 0; i < nbits; i++) begin
      for (int s = 0; s < spb; s++) begin
        @(negedge clk);
        get_out(inst, d, v, r);
        check_output($sformatf("sample_b%0d_s%0d", i, s), d, lut_ref[phase / 4]);
        check_output($sformatf("valid_b%0d_s%0d", i, s), v, 1);
        check_output($sformatf("ready_b%0d_s%0d", i, s), r, (s == spb - 1) ? 1 : 0);
        phase = (phase + (bits[i] ? STEP1 : STEP0)) % 256;
        if (abort_at >= 0 && i == 0 && s == abort_at) return;
        if (s == spb - 1) begin
          if (i + 1 < nbits) apply_stimulus(inst, bits[i+1], 1'b1);
          else               apply_stimulus(inst, 1'($urandom), 1'b0);
        end else begin
          apply_stimulus(inst, 1'($urandom), 1'($urandom));
        end
      end
    end
    @(negedge clk);
    get_out(inst, d, v, r);
    check_output("end_data", d, 128);
    check_output("end_valid", v, 0);
    check_output("end_ready", r, 1);
  endtask

  initial begin
    int d, v, r;
    int nb;
    logic [15:0] rb;

    for (int k = 0; k < 64; k++)
      lut_ref[k] = 128 + int'($floor(127.0 * $sin(2.0 * 3.14159265358979 * k / 64.0) + 0.5));

    // Reset with a pending bit: nothing may be accepted on the first edge after release.
    rst_n = 1'b0;
    apply_stimulus(0, 1'b1, 1'b1);
    apply_stimulus(1, 1'b0, 1'b0);
    #12;
    get_out(0, d, v, r);
    check_output("rst_data", d, 128);
    check_output("rst_valid", v, 0);
    check_output("rst_ready", r, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    get_out(0, d, v, r);
    check_output("post_rst_valid", v, 0);
    check_output("post_rst_ready", r, 1);
    check_output("post_rst_data", d, 128);
    apply_stimulus(0, 1'b0, 1'b0);

    $display("[TB] directed single bits and 1,0 pair");
    run_burst(0, SPB_A, 1, 16'b0, -1);
    run_burst(0, SPB_A, 1, 16'b1, -1);
    run_burst(0, SPB_A, 2, 16'b01, -1);

    $display("[TB] reset in the middle of a symbol");
    run_burst(0, SPB_A, 1, 16'b0, 20);
    #2;
    rst_n = 1'b0;
    apply_stimulus(0, 1'b0, 1'b0);
    #1;
    get_out(0, d, v, r);
    check_output("abort_data", d, 128);
    check_output("abort_valid", v, 0);
    check_output("abort_ready", r, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_burst(0, SPB_A, 1, 16'b1, -1);

    $display("[TB] random bursts");
    for (int t = 0; t < 4; t++) begin
      nb = $urandom_range(1, 4);
      rb = 16'($urandom);
      run_burst(0, SPB_A, nb, rb, -1);
    end

    $display("[TB] two samples per bit");
    run_burst(1, SPB_B, 8, 16'b0101_0101, -1);
    for (int t = 0; t < 3; t++) begin
      nb = $urandom_range(1, 12);
      rb = 16'($urandom);
      run_burst(1, SPB_B, nb, rb, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
